// File: rtl/fnd_message_scheduler.sv
// Picks what the 7-segment word shows: latched result, timed banner (ERROR/HAPPY/operator) or NULL.
// One-cycle latency from request to fnd_serial/busy/state; no backpressure, lower-priority banners are dropped.
module fnd_message_scheduler #(
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        result_valid,
    input  logic [31:0] result_data,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic        err_valid,
    input  logic        happy_valid,
    output logic [31:0] fnd_serial,
    output logic        busy,
    output logic [1:0]  state
);

    localparam int unsigned CNT_W = 25;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [31:0] C_NULL     = 32'h00CC_0000;
    localparam logic [31:0] C_ERROR    = 32'h00EE_0000;
    localparam logic [31:0] C_PLUS     = 32'h0010_0000;
    localparam logic [31:0] C_MINUS    = 32'h0020_0000;
    localparam logic [31:0] C_MULTIPLE = 32'h0030_0000;
    localparam logic [31:0] C_DIVID    = 32'h0040_0000;
    localparam logic [31:0] C_MODULO   = 32'h0050_0000;
    localparam logic [31:0] C_HAPPY    = 32'h00A0_0000;

    localparam logic [1:0] PRI_NONE  = 2'd0;
    localparam logic [1:0] PRI_OP    = 2'd1;
    localparam logic [1:0] PRI_HAPPY = 2'd2;
    localparam logic [1:0] PRI_ERR   = 2'd3;

    typedef enum logic [1:0] {
        S_BLANK  = 2'd0,
        S_RESULT = 2'd1,
        S_MSG    = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_fnd;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_last;
    logic             r_have;
    logic [1:0]       r_pri;

    logic             w_in_range;
    logic [31:0]      w_latched;
    logic             w_req;
    logic [1:0]       w_req_pri;
    logic [31:0]      w_req_code;
    logic             w_load;
    logic             w_have_nxt;
    logic [31:0]      w_last_nxt;

    assign w_in_range = ($signed(result_data) >= -32'sd99999) &&
                        ($signed(result_data) <= 32'sd999999);
    assign w_latched  = w_in_range ? result_data : C_ERROR;
    assign w_have_nxt = result_valid | r_have;
    assign w_last_nxt = result_valid ? w_latched : r_last;

    // Banner request decode; an unknown operator code escalates to an error banner.
    always_comb begin
        w_req      = 1'b0;
        w_req_pri  = PRI_NONE;
        w_req_code = C_NULL;
        if (err_valid) begin
            w_req      = 1'b1;
            w_req_pri  = PRI_ERR;
            w_req_code = C_ERROR;
        end else if (happy_valid) begin
            w_req      = 1'b1;
            w_req_pri  = PRI_HAPPY;
            w_req_code = C_HAPPY;
        end else if (op_valid) begin
            w_req     = 1'b1;
            w_req_pri = PRI_OP;
            case (op_code)
                3'd1:    w_req_code = C_PLUS;
                3'd2:    w_req_code = C_MINUS;
                3'd3:    w_req_code = C_MULTIPLE;
                3'd4:    w_req_code = C_DIVID;
                3'd5:    w_req_code = C_MODULO;
                default: begin
                    w_req_pri  = PRI_ERR;
                    w_req_code = C_ERROR;
                end
            endcase
        end
    end

    // A banner preempts the current one only at equal or higher priority; this also beats expiry.
    always_comb begin
        w_load = 1'b0;
        if (w_req) begin
            case (r_state)
                S_BLANK, S_RESULT: w_load = 1'b1;
                S_MSG:             w_load = (w_req_pri >= r_pri);
                default:           w_load = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BLANK;
            r_fnd   <= C_NULL;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_last  <= '0;
            r_have  <= 1'b0;
            r_pri   <= PRI_NONE;
        end else if (clr) begin
            r_state <= S_BLANK;
            r_fnd   <= C_NULL;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_last  <= '0;
            r_have  <= 1'b0;
            r_pri   <= PRI_NONE;
        end else begin
            if (result_valid) begin
                r_last <= w_latched;
                r_have <= 1'b1;
            end
            if (w_load) begin
                r_state <= S_MSG;
                r_fnd   <= w_req_code;
                r_busy  <= 1'b1;
                r_cnt   <= HOLD_LOAD;
                r_pri   <= w_req_pri;
            end else begin
                case (r_state)
                    S_BLANK, S_RESULT: begin
                        if (result_valid) begin
                            r_state <= S_RESULT;
                            r_fnd   <= w_latched;
                        end
                    end
                    S_MSG: begin
                        if (r_cnt == '0) begin
                            r_busy <= 1'b0;
                            r_pri  <= PRI_NONE;
                            if (w_have_nxt) begin
                                r_state <= S_RESULT;
                                r_fnd   <= w_last_nxt;
                            end else begin
                                r_state <= S_BLANK;
                                r_fnd   <= C_NULL;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_BLANK;
                        r_fnd   <= C_NULL;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_pri   <= PRI_NONE;
                    end
                endcase
            end
        end
    end

    assign fnd_serial = r_fnd;
    assign busy       = r_busy;
    assign state      = r_state;

endmodule

// File: tb/tb_fnd_message_scheduler.sv
// Bench for fnd_message_scheduler with HOLD_CYCLES=4: directed vector table plus randomized run vs a reference model.
module tb_fnd_message_scheduler;

    localparam int HOLD = 4;
    localparam logic [31:0] NUL = 32'h00CC_0000;
    localparam logic [31:0] ERR = 32'h00EE_0000;
    localparam logic [31:0] HAP = 32'h00A0_0000;

    logic        clk = 1'b0;
    logic        rst, clr, result_valid, op_valid, err_valid, happy_valid;
    logic [31:0] result_data;
    logic [2:0]  op_code;
    logic [31:0] fnd_serial;
    logic        busy;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fnd_message_scheduler #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .result_valid(result_valid), .result_data(result_data),
        .op_valid(op_valid), .op_code(op_code),
        .err_valid(err_valid), .happy_valid(happy_valid),
        .fnd_serial(fnd_serial), .busy(busy), .state(state)
    );

    typedef struct {
        logic        rst, clr, rv;
        logic [31:0] rd;
        logic        ov;
        logic [2:0]  oc;
        logic        ev, hv;
        logic [31:0] fnd;
        logic        busy;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic c, logic rv, logic [31:0] rd, logic ov, logic [2:0] oc,
                                logic ev, logic hv, logic [31:0] f, logic b, logic [1:0] s);
        vec_t v;
        v.rst = r; v.clr = c; v.rv = rv; v.rd = rd; v.ov = ov; v.oc = oc;
        v.ev = ev; v.hv = hv; v.fnd = f; v.busy = b; v.st = s;
        return v;
    endfunction

    task automatic drive(logic r, logic c, logic rv, logic [31:0] rd, logic ov, logic [2:0] oc,
                         logic ev, logic hv);
        @(negedge clk);
        rst = r; clr = c; result_valid = rv; result_data = rd;
        op_valid = ov; op_code = oc; err_valid = ev; happy_valid = hv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int idx, logic [31:0] ef, logic eb, logic [1:0] es);
        n_checks++;
        if (fnd_serial !== ef || busy !== eb || state !== es) begin
            n_fail++;
            $display("FAIL %s[%0d]: got fnd=%08h busy=%b state=%0d, want fnd=%08h busy=%b state=%0d",
                     name, idx, fnd_serial, busy, state, ef, eb, es);
        end
    endtask

    // Reference model: message time counted as cycles remaining on screen.
    int          m_mode;
    logic [31:0] m_fnd;
    int          m_left;
    int          m_pri;
    bit          m_have;
    logic [31:0] m_last;

    task automatic model_step(logic r, logic c, logic rv, logic [31:0] rd, logic ov, logic [2:0] oc,
                              logic ev, logic hv);
        int pri;
        logic [31:0] code;
        bit req;
        int sval;
        if (r || c) begin
            m_mode = 0; m_fnd = NUL; m_left = 0; m_pri = 0; m_have = 0; m_last = '0;
            return;
        end
        if (rv) begin
            sval = int'(rd);
            m_have = 1;
            m_last = (sval >= -99999 && sval <= 999999) ? rd : ERR;
        end
        req = 1; pri = 0; code = NUL;
        if (ev)                        begin pri = 3; code = ERR; end
        else if (hv)                   begin pri = 2; code = HAP; end
        else if (ov && oc >= 1 && oc <= 5) begin pri = 1; code = {8'h00, 1'b0, oc, 20'h0}; end
        else if (ov)                   begin pri = 3; code = ERR; end
        else req = 0;
        if (req && (m_mode != 2 || pri >= m_pri)) begin
            m_mode = 2; m_fnd = code; m_left = HOLD; m_pri = pri;
        end else if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = m_have ? 1 : 0;
                m_fnd  = m_have ? m_last : NUL;
            end
        end else if (rv) begin
            m_mode = 1; m_fnd = m_last;
        end
    endtask

    initial begin
        logic [31:0] rd_pool [8];
        logic r, c, rv, ov, ev, hv;
        logic [31:0] rd;
        logic [2:0]  oc;

        rst = 1'b1; clr = 1'b0; result_valid = 1'b0; result_data = '0;
        op_valid = 1'b0; op_code = '0; err_valid = 1'b0; happy_valid = 1'b0;

        //                 rst clr rv  rd            ov oc  ev hv  fnd            busy st
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, NUL,           0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, NUL,           0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0000_007B, 0, 0, 0, 0, 32'h0000_007B, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 2, 0, 0, 32'h0020_0000, 1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0020_0000, 1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0020_0000, 1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0020_0000, 1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_007B, 0, 1));
        vecs.push_back(mk(0, 0, 1, 32'hFFFE_7960, 0, 0, 0, 0, ERR,           0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h000F_423F, 0, 0, 0, 0, 32'h000F_423F, 0, 1));
        vecs.push_back(mk(0, 0, 1, 32'hFFFE_7961, 0, 0, 0, 0, 32'hFFFE_7961, 0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h000F_4240, 0, 0, 0, 0, ERR,           0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h0000_007B, 0, 0, 0, 0, 32'h0000_007B, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 0, 0, 32'h0010_0000, 1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 1, 0, ERR,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 3, 0, 0, ERR,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, ERR,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, ERR,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_007B, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 1, NUL,           0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 1, HAP,           1, 2));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0055, 0, 0, 0, 0, HAP,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, HAP,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, HAP,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_0055, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 0, NUL,           0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 4, 0, 0, 32'h0040_0000, 1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 5, 0, 0, 32'h0050_0000, 1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0050_0000, 1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0050_0000, 1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0050_0000, 1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, NUL,           0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 0, 0, ERR,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 1, ERR,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, ERR,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, ERR,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 1, 0, ERR,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, ERR,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, ERR,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, ERR,           1, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, NUL,           0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 1, HAP,           1, 2));
        vecs.push_back(mk(1, 1, 1, 32'h0000_0001, 1, 1, 1, 1, NUL,           0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, NUL,           0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].rv, vecs[i].rd, vecs[i].ov, vecs[i].oc,
                  vecs[i].ev, vecs[i].hv);
            check("vec", i, vecs[i].fnd, vecs[i].busy, vecs[i].st);
        end

        // Multi-cycle corner: expiry with a result arriving on the same cycle shows the new result.
        drive(0, 0, 0, 32'h0, 1, 2, 0, 0);
        for (int k = 0; k < HOLD - 1; k++) drive(0, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(0, 0, 1, 32'h0000_0321, 0, 0, 0, 0);
        check("expiry_rv", 0, 32'h0000_0321, 1'b0, 2'd1);

        rd_pool[0] = 32'hFFFE_7960; rd_pool[1] = 32'hFFFE_7961; rd_pool[2] = 32'h000F_423F;
        rd_pool[3] = 32'h000F_4240; rd_pool[4] = 32'h0;         rd_pool[5] = 32'hFFFF_FFFF;
        rd_pool[6] = 32'h8000_0000; rd_pool[7] = 32'h7FFF_FFFF;

        drive(1, 0, 0, 32'h0, 0, 0, 0, 0);
        model_step(1, 0, 0, 32'h0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 39) == 0);
            rv = ($urandom_range(0, 5) == 0);
            ov = ($urandom_range(0, 11) == 0);
            ev = ($urandom_range(0, 24) == 0);
            hv = ($urandom_range(0, 19) == 0);
            oc = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) rd = rd_pool[$urandom_range(0, 7)];
            else if ($urandom_range(0, 1) == 0) rd = 32'($urandom_range(0, 1100000)) - 32'd100500;
            else rd = $urandom;
            drive(r, c, rv, rd, ov, oc, ev, hv);
            model_step(r, c, rv, rd, ov, oc, ev, hv);
            check("rand", n, m_fnd, (m_mode == 2), 2'(m_mode));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
